// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - request, data-memory and writeback signals of mem_access_ctrl
interface mem_access_ctrl_if #(
    parameter int RD_W = 3
);
    logic            req_valid;
    logic            req_ready;
    logic            req_read;
    logic            req_write;
    logic [7:0]      req_addr;
    logic [7:0]      req_wdata;
    logic [RD_W-1:0] req_rd;
    logic            dm_mem_read;
    logic            dm_mem_write;
    logic [7:0]      dm_addr;
    logic [7:0]      dm_wdata;
    logic [7:0]      dm_rdata;
    logic            retire;
    logic            wb_en;
    logic [RD_W-1:0] wb_rd;
    logic [7:0]      wb_data;
    logic            err;

    // the sequencing stage itself
    modport slave (
        input  req_valid, req_read, req_write, req_addr, req_wdata, req_rd, dm_rdata,
        output req_ready, dm_mem_read, dm_mem_write, dm_addr, dm_wdata,
        output retire, wb_en, wb_rd, wb_data, err
    );

    // execute stage, data memory and register file seen together
    modport master (
        output req_valid, req_read, req_write, req_addr, req_wdata, req_rd, dm_rdata,
        input  req_ready, dm_mem_read, dm_mem_write, dm_addr, dm_wdata,
        input  retire, wb_en, wb_rd, wb_data, err
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store sequencer between execute stage and data memory
module mem_access_ctrl #(
    parameter int READ_LAT  = 1,
    parameter int MEM_DEPTH = 256,
    parameter int RD_W      = 3
) (
    input  logic              clk,
    input  logic              reset,
    mem_access_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t          state_q;
    logic [7:0]      addr_q;
    logic [7:0]      wdata_q;
    logic [RD_W-1:0] rd_q;
    logic [2:0]      cnt_q;
    logic            ready_q;
    logic            mem_read_q;
    logic            mem_write_q;
    logic            retire_q;
    logic            wb_en_q;
    logic            err_q;
    logic [RD_W-1:0] wb_rd_q;
    logic [7:0]      wb_data_q;

    logic xfer;
    logic in_range;
    logic req_load;
    logic req_store;
    logic req_oob;

    // Decode the incoming request; read wins over write, a no-op is never an error
    always_comb begin
        xfer      = bus.req_valid & ready_q;
        in_range  = ({1'b0, bus.req_addr} < 9'(MEM_DEPTH));
        req_load  = bus.req_read & in_range;
        req_store = bus.req_write & ~bus.req_read & in_range;
        req_oob   = (bus.req_read | bus.req_write) & ~in_range;
    end

    // Sequencer: all outputs are produced one edge ahead so they leave as flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            retire_q    <= 1'b0;
            wb_en_q     <= 1'b0;
            err_q       <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
        end else begin
            retire_q <= 1'b0;
            wb_en_q  <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE, RESP: begin
                    if (xfer) begin
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        rd_q        <= bus.req_rd;
                        cnt_q       <= 3'(READ_LAT);
                        ready_q     <= 1'b0;
                        mem_read_q  <= req_load;
                        mem_write_q <= req_store;
                        // stores, no-ops and range errors complete in the ACCESS cycle
                        retire_q    <= ~req_load;
                        err_q       <= req_oob;
                        state_q     <= ACCESS;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACCESS, WAIT: begin
                    if (mem_read_q) begin
                        // cnt_q counts the read cycles left, including this one
                        if (cnt_q == 3'd1) begin
                            wb_data_q  <= bus.dm_rdata;
                            wb_rd_q    <= rd_q;
                            mem_read_q <= 1'b0;
                            retire_q   <= 1'b1;
                            wb_en_q    <= 1'b1;
                            ready_q    <= 1'b1;
                            state_q    <= RESP;
                        end else begin
                            cnt_q   <= cnt_q - 3'd1;
                            state_q <= WAIT;
                        end
                    end else begin
                        mem_write_q <= 1'b0;
                        ready_q     <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    ready_q     <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready    = ready_q;
    assign bus.dm_mem_read  = mem_read_q;
    assign bus.dm_mem_write = mem_write_q;
    assign bus.dm_addr      = addr_q;
    assign bus.dm_wdata     = wdata_q;
    assign bus.retire       = retire_q;
    assign bus.wb_en        = wb_en_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.err          = err_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl across latencies and depths
module tb_mem_access_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp    = 0;
    int n_bad    = 0;
    int done_cnt = 0;

    localparam int NINST = 5;
    localparam int NREQ  = 15;

    typedef struct {
        bit         rd;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [2:0] rdi;
        bit         chk;
        logic [7:0] exp;
    } req_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic req_t get_req(input int i);
        req_t r;
        r = '{1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00};
        case (i)
            0:  r = '{1'b0, 1'b1, 8'h20, 8'h5A, 3'd0, 1'b1, 8'h00};
            1:  r = '{1'b1, 1'b0, 8'h20, 8'h00, 3'd3, 1'b1, 8'h5A};
            2:  r = '{1'b0, 1'b1, 8'h01, 8'h11, 3'd0, 1'b0, 8'h00};
            3:  r = '{1'b0, 1'b1, 8'h02, 8'h22, 3'd0, 1'b0, 8'h00};
            4:  r = '{1'b0, 1'b1, 8'h03, 8'h33, 3'd0, 1'b0, 8'h00};
            5:  r = '{1'b1, 1'b0, 8'h01, 8'h00, 3'd1, 1'b0, 8'h00};
            6:  r = '{1'b1, 1'b0, 8'h02, 8'h00, 3'd2, 1'b0, 8'h00};
            7:  r = '{1'b1, 1'b0, 8'h03, 8'h00, 3'd5, 1'b0, 8'h00};
            8:  r = '{1'b1, 1'b0, 8'h80, 8'h00, 3'd4, 1'b1, 8'h00};
            9:  r = '{1'b1, 1'b1, 8'h02, 8'hEE, 3'd6, 1'b1, 8'h22};
            10: r = '{1'b0, 1'b0, 8'h30, 8'h77, 3'd0, 1'b1, 8'h00};
            11: r = '{1'b0, 1'b1, 8'hFF, 8'hC3, 3'd0, 1'b0, 8'h00};
            12: r = '{1'b1, 1'b0, 8'hFF, 8'h00, 3'd7, 1'b1, 8'hC3};
            13: r = '{1'b1, 1'b0, 8'h03, 8'h00, 3'd1, 1'b0, 8'h00};
            default: r = '{1'b1, 1'b0, 8'h01, 8'h00, 3'd2, 1'b0, 8'h00};
        endcase
        return r;
    endfunction

    for (genvar g = 0; g < NINST; g++) begin : g_inst
        localparam int L = (g < 4) ? g + 1 : 1;
        localparam int D = (g < 4) ? 256 : 128;

        logic rst;
        int   cyc = 0;
        int   rdc;
        logic [7:0] mem [256];

        mem_access_ctrl_if #(.RD_W(3)) bus ();

        mem_access_ctrl #(.READ_LAT(L), .MEM_DEPTH(D), .RD_W(3)) u_dut (
            .clk   (clk),
            .reset (rst),
            .bus   (bus.slave)
        );

        always @(posedge clk) cyc <= cyc + 1;

        // data memory: read data is only correct in the READ_LAT-th consecutive read cycle
        always @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            end else if (bus.dm_mem_write) begin
                mem[bus.dm_addr] <= bus.dm_wdata;
            end
        end
        always @(posedge clk or posedge rst) begin
            if (rst) rdc <= 0;
            else     rdc <= bus.dm_mem_read ? rdc + 1 : 0;
        end
        assign bus.dm_rdata = (bus.dm_mem_read && rdc == L - 1) ? mem[bus.dm_addr]
                                                                 : (mem[bus.dm_addr] ^ 8'hA5);

        // model: per-cycle expectations scheduled from each observed transfer
        bit         e_ret  [int];
        bit         e_wb   [int];
        bit         e_err  [int];
        bit         e_mr   [int];
        bit         e_mw   [int];
        bit         e_busy [int];
        logic [7:0] e_data [int];
        logic [2:0] e_rd   [int];
        logic [7:0] mmem [256];
        logic [7:0] m_addr, m_wdata, m_wb, p_addr, p_wdata;
        bit         p_valid;

        always @(negedge clk) begin
            int c;
            c = cyc;
            if (rst) begin
                e_ret.delete(); e_wb.delete(); e_err.delete(); e_mr.delete();
                e_mw.delete(); e_busy.delete(); e_data.delete(); e_rd.delete();
                for (int i = 0; i < 256; i++) mmem[i] = 8'h00;
                m_addr = 8'h00; m_wdata = 8'h00; m_wb = 8'h00; p_valid = 1'b0;
            end else begin
                if (p_valid) begin
                    m_addr  = p_addr;
                    m_wdata = p_wdata;
                    p_valid = 1'b0;
                end
                if (e_wb.exists(c)) m_wb = e_data[c];
                check($sformatf("u%0d c%0d ready", g, c), 32'(bus.req_ready), 32'(!e_busy.exists(c)));
                check($sformatf("u%0d c%0d mem_read", g, c), 32'(bus.dm_mem_read), 32'(e_mr.exists(c)));
                check($sformatf("u%0d c%0d mem_write", g, c), 32'(bus.dm_mem_write), 32'(e_mw.exists(c)));
                check($sformatf("u%0d c%0d retire", g, c), 32'(bus.retire), 32'(e_ret.exists(c)));
                check($sformatf("u%0d c%0d wb_en", g, c), 32'(bus.wb_en), 32'(e_wb.exists(c)));
                check($sformatf("u%0d c%0d err", g, c), 32'(bus.err), 32'(e_err.exists(c)));
                check($sformatf("u%0d c%0d dm_addr", g, c), 32'(bus.dm_addr), 32'(m_addr));
                check($sformatf("u%0d c%0d dm_wdata", g, c), 32'(bus.dm_wdata), 32'(m_wdata));
                check($sformatf("u%0d c%0d wb_data", g, c), 32'(bus.wb_data), 32'(m_wb));
                if (e_wb.exists(c))
                    check($sformatf("u%0d c%0d wb_rd", g, c), 32'(bus.wb_rd), 32'(e_rd[c]));
                if (bus.req_valid && bus.req_ready) begin
                    bit inr;
                    inr     = int'(bus.req_addr) < D;
                    p_valid = 1'b1;
                    p_addr  = bus.req_addr;
                    p_wdata = bus.req_wdata;
                    if (bus.req_read && inr) begin
                        for (int k = 1; k <= L; k++) begin
                            e_mr[c + k]   = 1'b1;
                            e_busy[c + k] = 1'b1;
                        end
                        e_ret[c + L + 1]  = 1'b1;
                        e_wb[c + L + 1]   = 1'b1;
                        e_data[c + L + 1] = mmem[bus.req_addr];
                        e_rd[c + L + 1]   = bus.req_rd;
                    end else begin
                        e_busy[c + 1] = 1'b1;
                        e_ret[c + 1]  = 1'b1;
                        if (bus.req_write && inr) begin
                            e_mw[c + 1] = 1'b1;
                            mmem[bus.req_addr] = bus.req_wdata;
                        end
                        if ((bus.req_read || bus.req_write) && !inr) e_err[c + 1] = 1'b1;
                    end
                end
            end
        end

        // directed stimulus with literal expectations on the flagged requests
        initial begin
            req_t r;
            int   tc;
            bit   got;
            bit   oob;
            int   rcnt;
            rst = 1'b1;
            bus.req_valid = 1'b0; bus.req_read = 1'b0; bus.req_write = 1'b0;
            bus.req_addr = 8'h00; bus.req_wdata = 8'h00; bus.req_rd = 3'd0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            check($sformatf("u%0d reset ready", g), 32'(bus.req_ready), 1);
            check($sformatf("u%0d reset mem_read", g), 32'(bus.dm_mem_read), 0);
            check($sformatf("u%0d reset mem_write", g), 32'(bus.dm_mem_write), 0);
            check($sformatf("u%0d reset dm_addr", g), 32'(bus.dm_addr), 0);
            check($sformatf("u%0d reset dm_wdata", g), 32'(bus.dm_wdata), 0);
            check($sformatf("u%0d reset retire", g), 32'(bus.retire), 0);
            check($sformatf("u%0d reset wb_en", g), 32'(bus.wb_en), 0);
            check($sformatf("u%0d reset err", g), 32'(bus.err), 0);
            check($sformatf("u%0d reset wb_rd", g), 32'(bus.wb_rd), 0);
            check($sformatf("u%0d reset wb_data", g), 32'(bus.wb_data), 0);
            @(posedge clk); #1;
            rst = 1'b0;

            for (int i = 0; i < NREQ; i++) begin
                r = get_req(i);
                bus.req_valid = 1'b1; bus.req_read = r.rd; bus.req_write = r.wr;
                bus.req_addr = r.addr; bus.req_wdata = r.wdata; bus.req_rd = r.rdi;
                got = 1'b0;
                for (int to = 0; to < 20 && !got; to++) begin
                    @(negedge clk);
                    got = bus.req_ready;
                end
                check($sformatf("u%0d req%0d accepted", g, i), 32'(got), 1);
                tc = cyc;
                @(posedge clk); #1;
                if (!got) begin
                    bus.req_valid = 1'b0;
                end else if (r.chk) begin
                    bus.req_valid = 1'b0;
                    oob = (r.rd || r.wr) && (int'(r.addr) >= D);
                    if (r.rd && !oob) begin
                        for (int k = 1; k <= L; k++) begin
                            @(negedge clk);
                            check($sformatf("u%0d req%0d rd cyc%0d mem_read", g, i, k), 32'(bus.dm_mem_read), 1);
                            check($sformatf("u%0d req%0d rd cyc%0d mem_write", g, i, k), 32'(bus.dm_mem_write), 0);
                            check($sformatf("u%0d req%0d rd cyc%0d ready", g, i, k), 32'(bus.req_ready), 0);
                        end
                        @(negedge clk);
                        check($sformatf("u%0d req%0d wb cycle", g, i), 32'(cyc - tc), 32'(L + 1));
                        check($sformatf("u%0d req%0d retire", g, i), 32'(bus.retire), 1);
                        check($sformatf("u%0d req%0d wb_en", g, i), 32'(bus.wb_en), 1);
                        check($sformatf("u%0d req%0d wb_rd", g, i), 32'(bus.wb_rd), 32'(r.rdi));
                        check($sformatf("u%0d req%0d wb_data", g, i), 32'(bus.wb_data), 32'(r.exp));
                        check($sformatf("u%0d req%0d mem_read off", g, i), 32'(bus.dm_mem_read), 0);
                    end else begin
                        @(negedge clk);
                        check($sformatf("u%0d req%0d retire", g, i), 32'(bus.retire), 1);
                        check($sformatf("u%0d req%0d wb_en", g, i), 32'(bus.wb_en), 0);
                        check($sformatf("u%0d req%0d err", g, i), 32'(bus.err), 32'(oob));
                        check($sformatf("u%0d req%0d mem_read", g, i), 32'(bus.dm_mem_read), 0);
                        check($sformatf("u%0d req%0d mem_write", g, i), 32'(bus.dm_mem_write), 32'(r.wr && !oob));
                        check($sformatf("u%0d req%0d dm_addr", g, i), 32'(bus.dm_addr), 32'(r.addr));
                        check($sformatf("u%0d req%0d dm_wdata", g, i), 32'(bus.dm_wdata), 32'(r.wdata));
                    end
                    @(posedge clk); #1;
                end else if (i == NREQ - 1) begin
                    bus.req_valid = 1'b0;
                end
            end

            // load 0x10, then reset while the read is still outstanding
            repeat (2) @(posedge clk); #1;
            bus.req_valid = 1'b1; bus.req_read = 1'b1; bus.req_write = 1'b0;
            bus.req_addr = 8'h10; bus.req_wdata = 8'h00; bus.req_rd = 3'd2;
            got = 1'b0;
            for (int to = 0; to < 20 && !got; to++) begin
                @(negedge clk);
                got = bus.req_ready;
            end
            check($sformatf("u%0d rstload accepted", g), 32'(got), 1);
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
            repeat (L - 1) @(posedge clk);
            #2;
            rst = 1'b1;
            #1;
            check($sformatf("u%0d midreset mem_read", g), 32'(bus.dm_mem_read), 0);
            check($sformatf("u%0d midreset mem_write", g), 32'(bus.dm_mem_write), 0);
            check($sformatf("u%0d midreset dm_addr", g), 32'(bus.dm_addr), 0);
            check($sformatf("u%0d midreset ready", g), 32'(bus.req_ready), 1);
            check($sformatf("u%0d midreset retire", g), 32'(bus.retire), 0);
            repeat (2) @(posedge clk); #1;
            rst = 1'b0;
            rcnt = 0;
            repeat (L + 3) begin
                @(negedge clk);
                if (bus.retire) rcnt++;
            end
            check($sformatf("u%0d dropped load retires", g), 32'(rcnt), 0);
            repeat (2) @(posedge clk);
            done_cnt++;
        end
    end

    initial begin
        for (int w = 0; w < 5000 && done_cnt < NINST; w++) @(posedge clk);
        if (done_cnt < NINST) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run timeout: got %0d finished drivers expected %0d", done_cnt, NINST);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencing stage between the execute stage and `data_memory`. Accepts one load/store request per transaction over a valid/ready handshake, registers it, and drives the memory's `mem_read`/`mem_write`/`r_a`/`r_b` inputs for the required number of cycles. It then captures load data and issues a single-cycle retire/writeback pulse to the register-file write port. It also range-checks addresses and stalls upstream while an access is in flight.

## Interface
- `READ_LAT`, 1: cycles from first `dm_mem_read` cycle until `dm_rdata` is valid; legal range 1–4.
- `MEM_DEPTH`, 256: number of implemented bytes; legal addresses are 0..MEM_DEPTH-1.
- `RD_W`, 3: width of the destination register index.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  upstream request present.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_read`  in  1  request is a load.
- `req_write`  in  1  request is a store.
- `req_addr`  in  8  byte address.
- `req_wdata`  in  8  store data.
- `req_rd`  in  RD_W  load destination register.
- `dm_mem_read`  out  1  to `data_memory.mem_read`.
- `dm_mem_write`  out  1  to `data_memory.mem_write`.
- `dm_addr`  out  8  to `data_memory.r_a`.
- `dm_wdata`  out  8  to `data_memory.r_b`.
- `dm_rdata`  in  8  from `data_memory.data_out`.
- `retire`  out  1  one-cycle pulse: request complete.
- `wb_en`  out  1  register-file write enable, qualified by `retire`.
- `wb_rd`  out  RD_W  writeback destination.
- `wb_data`  out  8  load result.
- `err`  out  1  one-cycle pulse with `retire`: address out of range.

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- Handshake: transfer occurs when `req_valid & req_ready`. `req_ready` = 1 in IDLE and RESP, and 0 in ACCESS and WAIT. Request fields are registered on transfer and are ignored otherwise.
- Op decode: `req_read` has priority over `req_write`, matching memory priority. Both 0 is a no-op.
- IDLE → ACCESS on transfer.
- ACCESS, store: `dm_mem_write`=1, `dm_addr`/`dm_wdata` taken from registers. `retire`=1, `wb_en`=0 this cycle. Next state IDLE.
- ACCESS, load: `dm_mem_read`=1. Latency counter loaded with READ_LAT. Next state WAIT.
- ACCESS, no-op or address ≥ MEM_DEPTH: no `dm_*` strobe. `retire`=1, `wb_en`=0, and `err`=1 only for the out-of-range case. Next state IDLE.
- WAIT: `dm_mem_read` stays 1 and `dm_addr` stays stable. The counter decrements each cycle. When the counter reaches 1, `dm_rdata` is captured into `wb_data` and the next state is RESP.
- RESP: `retire`=1, `wb_en`=1, `wb_rd`=registered rd, `wb_data`=captured byte.
- RESP exit: if a transfer occurs in RESP, go to ACCESS (back-to-back); otherwise go to IDLE.
- `dm_mem_read` and `dm_mem_write` are never both 1.
- `dm_*` strobes are 0 in IDLE and RESP. `dm_addr`/`dm_wdata` hold their last registered value when idle.
- `wb_data` holds its value until the next load capture.
- Reset (async, any state, including mid-WAIT): state IDLE, counter 0, all request registers 0. A pending load is dropped with no retire.

## Timing
- Reset values: `req_ready`=1; `dm_mem_read`, `dm_mem_write`, `dm_addr`, `dm_wdata`=0; `retire`, `wb_en`, `err`, `wb_rd`, `wb_data`=0.
- Store: transfer in cycle 0, memory write strobe in cycle 1, `retire` in cycle 1. Next request may transfer in cycle 2.
- Load: transfer in cycle 0; `dm_mem_read` from cycle 1 through cycle READ_LAT; `dm_rdata` sampled at the end of cycle READ_LAT. `retire`/`wb_en` in cycle READ_LAT+1. Load-to-writeback is READ_LAT+1 cycles after transfer.
- No-op / error: `retire` in cycle 1.
- Back-to-back loads: the next transfer is allowed in the RESP cycle, giving throughput of one load per READ_LAT+1 cycles.
- All outputs are registered or decoded from registered state. No combinational path from `req_*` to `dm_*` or `wb_*`.

## Test plan
- Reset mid-load: READ_LAT=2, load addr 0x10, assert `reset` in the WAIT cycle → `retire` never pulses, `req_ready`=1, all `dm_*` outputs 0 immediately.
- Store then load: store 0x5A to 0x20 → `dm_mem_write`=1 with `dm_addr`=0x20 and `dm_wdata`=0x5A in cycle 1, `retire`=1, `wb_en`=0. Then load 0x20 with rd=3 (READ_LAT=1) → `retire`=1, `wb_en`=1, `wb_rd`=3, `wb_data`=0x5A two cycles after transfer.
- Latency sweep: READ_LAT=1..4, load 0xFF → `dm_mem_read` high for exactly READ_LAT cycles; `wb_en` arrives READ_LAT+1 cycles after transfer; `req_ready`=0 throughout.
- Back-to-back loads: hold `req_valid` with addresses 0x01, 0x02, 0x03 → transfers occur in IDLE and RESP cycles only; three `wb_en` pulses in order with the correct data; no request lost or duplicated.
- Out-of-range: MEM_DEPTH=128, load 0x80 → no `dm_*` strobe; `retire`=1, `err`=1, `wb_en`=0 in cycle 1.
- Op-decode edge cases: request with both `req_read`/`req_write` set → load path only, `dm_mem_write` never asserted. Request with both clear → `retire` in cycle 1 with no strobe and `err`=0.
